// File: rtl/fnd_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fnd_display_arbiter
// Description : Chooses what the 4-digit FND shows (brew animation, error,
//               price message or idle balance, highest priority first),
//               drives the FND controller's data/animation inputs and runs
//               the brew watchdog.
// Revision    : 1.0  initial release
// ============================================================================
module fnd_display_arbiter #(
    parameter int          MSG_HOLD_CYCLES = 200_000_000,
    parameter int          BREW_TIMEOUT    = 600_000_000,
    parameter logic [13:0] ERR_CODE        = 14'd11111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] balance,
    input  logic        price_req,
    input  logic [13:0] price_val,
    input  logic        err_req,
    input  logic        brew_start,
    input  logic        timer_done,
    output logic [13:0] disp_data,
    output logic        anim_en,
    output logic        brew_done,
    output logic        brew_fault,
    output logic [1:0]  src
);

    // Counter widths; a minimum of one bit keeps degenerate values legal.
    localparam int c_HOLD_W = (MSG_HOLD_CYCLES > 1) ? $clog2(MSG_HOLD_CYCLES) : 1;
    localparam int c_WD_W   = (BREW_TIMEOUT > 1)    ? $clog2(BREW_TIMEOUT)    : 1;

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MSG_HOLD_CYCLES - 1);
    localparam logic [c_WD_W-1:0]   c_WD_LAST   = c_WD_W'(BREW_TIMEOUT - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [c_WD_W-1:0]   c_WD_ONE    = c_WD_W'(1);

    // The state encoding doubles as the src output code.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MSG  = 2'd1,
        S_ERR  = 2'd2,
        S_BREW = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [c_WD_W-1:0]   r_wd_cnt;
    logic [c_WD_W-1:0]   w_wd_nxt;
    logic                r_err_pending;
    logic                w_err_pending_nxt;
    logic [13:0]         r_price;
    logic [13:0]         w_price_nxt;
    logic                w_brew_done_nxt;
    logic                w_brew_fault_nxt;
    logic [13:0]         w_disp_nxt;

    logic [13:0]         r_disp_data;
    logic                r_anim_en;
    logic                r_brew_done;
    logic                r_brew_fault;

    // State, counters and all outputs; reset acts immediately so anim_en
    // drops (clearing the FND controller timers) without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_hold_cnt    <= '0;
            r_wd_cnt      <= '0;
            r_err_pending <= 1'b0;
            r_price       <= '0;
            r_disp_data   <= '0;
            r_anim_en     <= 1'b0;
            r_brew_done   <= 1'b0;
            r_brew_fault  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_wd_cnt      <= w_wd_nxt;
            r_err_pending <= w_err_pending_nxt;
            r_price       <= w_price_nxt;
            r_disp_data   <= w_disp_nxt;
            r_anim_en     <= (w_state_nxt == S_BREW);
            r_brew_done   <= w_brew_done_nxt;
            r_brew_fault  <= w_brew_fault_nxt;
        end
    end

    // Next-state arbitration: brew beats error beats price in every state.
    always_comb begin
        w_state_nxt       = r_state;
        w_hold_nxt        = r_hold_cnt;
        w_wd_nxt          = r_wd_cnt;
        w_err_pending_nxt = r_err_pending;
        w_price_nxt       = r_price;
        w_brew_done_nxt   = 1'b0;
        w_brew_fault_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (brew_start) begin
                    w_state_nxt = S_BREW;
                    w_wd_nxt    = '0;
                end else if (err_req) begin
                    w_state_nxt = S_ERR;
                    w_hold_nxt  = '0;
                end else if (price_req) begin
                    w_state_nxt = S_MSG;
                    w_price_nxt = price_val;
                    w_hold_nxt  = '0;
                end
            end

            S_MSG: begin
                w_hold_nxt = r_hold_cnt + c_HOLD_ONE;
                if (brew_start) begin
                    w_state_nxt = S_BREW;
                    w_wd_nxt    = '0;
                end else if (err_req) begin
                    w_state_nxt = S_ERR;
                    w_hold_nxt  = '0;
                end else if (price_req) begin
                    w_price_nxt = price_val;
                    w_hold_nxt  = '0;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_hold_nxt  = '0;
                end
            end

            S_ERR: begin
                // A price request is dropped while an error is shown.
                w_hold_nxt = r_hold_cnt + c_HOLD_ONE;
                if (brew_start) begin
                    w_state_nxt = S_BREW;
                    w_wd_nxt    = '0;
                end else if (err_req) begin
                    w_hold_nxt  = '0;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_hold_nxt  = '0;
                end
            end

            default: begin  // S_BREW
                w_wd_nxt = r_wd_cnt + c_WD_ONE;
                if (err_req) begin
                    w_err_pending_nxt = 1'b1;
                end
                // timer_done wins over a coincident watchdog expiry.
                if (timer_done) begin
                    w_brew_done_nxt   = 1'b1;
                    w_err_pending_nxt = 1'b0;
                    w_hold_nxt        = '0;
                    w_state_nxt       = (r_err_pending || err_req) ? S_ERR : S_IDLE;
                end else if (r_wd_cnt == c_WD_LAST) begin
                    w_brew_fault_nxt  = 1'b1;
                    w_err_pending_nxt = 1'b0;
                    w_hold_nxt        = '0;
                    w_state_nxt       = S_ERR;
                end
            end
        endcase
    end

    // Display value follows the state being entered, so it changes together
    // with src and anim_en.
    always_comb begin
        w_disp_nxt = '0;
        case (w_state_nxt)
            S_IDLE:  w_disp_nxt = balance;
            S_MSG:   w_disp_nxt = w_price_nxt;
            S_ERR:   w_disp_nxt = ERR_CODE;
            default: w_disp_nxt = '0;
        endcase
    end

    assign disp_data  = r_disp_data;
    assign anim_en    = r_anim_en;
    assign brew_done  = r_brew_done;
    assign brew_fault = r_brew_fault;
    assign src        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fnd_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fnd_display_arbiter
// Description : Directed scoreboard bench for fnd_display_arbiter
//               (MSG_HOLD_CYCLES = 10, BREW_TIMEOUT = 50).
// Revision    : 1.0  initial release
// ============================================================================
module tb_fnd_display_arbiter;

    localparam int          c_HOLD = 10;
    localparam int          c_TO   = 50;
    localparam logic [13:0] c_ERR  = 14'd11111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] balance = '0;
    logic        price_req = 1'b0;
    logic [13:0] price_val = '0;
    logic        err_req = 1'b0;
    logic        brew_start = 1'b0;
    logic        timer_done = 1'b0;
    logic [13:0] disp_data;
    logic        anim_en;
    logic        brew_done;
    logic        brew_fault;
    logic [1:0]  src;

    typedef struct packed {
        logic [13:0] d;
        logic [1:0]  s;
        logic        a;
        logic        dn;
        logic        f;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    fnd_display_arbiter #(
        .MSG_HOLD_CYCLES (c_HOLD),
        .BREW_TIMEOUT    (c_TO),
        .ERR_CODE        (c_ERR)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .balance    (balance),
        .price_req  (price_req),
        .price_val  (price_val),
        .err_req    (err_req),
        .brew_start (brew_start),
        .timer_done (timer_done),
        .disp_data  (disp_data),
        .anim_en    (anim_en),
        .brew_done  (brew_done),
        .brew_fault (brew_fault),
        .src        (src)
    );

    always #5 clk = ~clk;

    // Push the expected post-edge outputs, let one edge happen, drop pulses.
    task automatic cyc(input logic [13:0] d, input logic [1:0] s,
                       input logic a, input logic dn, input logic f);
        exp_t e;
        e.d = d; e.s = s; e.a = a; e.dn = dn; e.f = f;
        q.push_back(e);
        @(negedge clk);
        price_req  = 1'b0;
        err_req    = 1'b0;
        brew_start = 1'b0;
        timer_done = 1'b0;
    endtask

    task automatic check_now(input string name, input exp_t e);
        exp_t act;
        act = {disp_data, src, anim_en, brew_done, brew_fault};
        n_total++;
        if (act === e) n_pass++;
        else $display("FAIL %s: got disp=%0d src=%0d anim=%0b done=%0b fault=%0b, want disp=%0d src=%0d anim=%0b done=%0b fault=%0b",
                      name, act.d, act.s, act.a, act.dn, act.f, e.d, e.s, e.a, e.dn, e.f);
    endtask

    // Monitor: outputs are valid every cycle, compared 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_now("cycle", e);
            end
        end
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d/%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset takes effect at once.
        reset = 1'b1;
        #2;
        check_now("reset_state", '{d:14'd0, s:2'd0, a:1'b0, dn:1'b0, f:1'b0});
        @(negedge clk);

        // 1: idle balance tracking with one-cycle latency
        reset   = 1'b0;
        balance = 14'd1500;
        cyc(14'd1500, 2'd0, 1'b0, 1'b0, 1'b0);
        balance = 14'd2000;
        cyc(14'd2000, 2'd0, 1'b0, 1'b0, 1'b0);

        // 2a: price shown exactly 10 cycles
        price_val = 14'd3000;
        price_req = 1'b1;
        for (int i = 0; i < c_HOLD; i++) cyc(14'd3000, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(14'd2000, 2'd0, 1'b0, 1'b0, 1'b0);

        // 2b: relatch at message cycle 5 restarts the 10-cycle hold
        price_req = 1'b1;
        for (int i = 0; i < 5; i++) cyc(14'd3000, 2'd1, 1'b0, 1'b0, 1'b0);
        price_val = 14'd4000;
        price_req = 1'b1;
        for (int i = 0; i < c_HOLD; i++) cyc(14'd4000, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(14'd2000, 2'd0, 1'b0, 1'b0, 1'b0);

        // 3: simultaneous requests in IDLE -> brew wins, error not remembered
        price_val  = 14'd5555;
        price_req  = 1'b1;
        err_req    = 1'b1;
        brew_start = 1'b1;
        for (int i = 0; i < 4; i++) cyc(14'd0, 2'd3, 1'b1, 1'b0, 1'b0);
        timer_done = 1'b1;
        cyc(14'd2000, 2'd0, 1'b0, 1'b1, 1'b0);

        // 4: error during brew deferred until timer_done
        brew_start = 1'b1;
        cyc(14'd0, 2'd3, 1'b1, 1'b0, 1'b0);
        cyc(14'd0, 2'd3, 1'b1, 1'b0, 1'b0);
        err_req = 1'b1;
        cyc(14'd0, 2'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 4; i < 20; i++) cyc(14'd0, 2'd3, 1'b1, 1'b0, 1'b0);
        timer_done = 1'b1;
        cyc(c_ERR, 2'd2, 1'b0, 1'b1, 1'b0);             // ERR cycle 1
        cyc(c_ERR, 2'd2, 1'b0, 1'b0, 1'b0);             // ERR cycle 2
        price_val = 14'd7777;
        price_req = 1'b1;                               // dropped in ERR
        cyc(c_ERR, 2'd2, 1'b0, 1'b0, 1'b0);
        cyc(c_ERR, 2'd2, 1'b0, 1'b0, 1'b0);
        err_req = 1'b1;                                 // restarts hold
        for (int i = 0; i < c_HOLD; i++) cyc(c_ERR, 2'd2, 1'b0, 1'b0, 1'b0);
        balance = 14'd16000;                            // out of range passes through
        cyc(14'd16000, 2'd0, 1'b0, 1'b0, 1'b0);
        balance = 14'd2000;
        cyc(14'd2000, 2'd0, 1'b0, 1'b0, 1'b0);

        // 5a: watchdog expiry after 50 brew cycles
        brew_start = 1'b1;
        for (int i = 0; i < c_TO; i++) cyc(14'd0, 2'd3, 1'b1, 1'b0, 1'b0);
        cyc(c_ERR, 2'd2, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i < c_HOLD; i++) cyc(c_ERR, 2'd2, 1'b0, 1'b0, 1'b0);
        cyc(14'd2000, 2'd0, 1'b0, 1'b0, 1'b0);

        // 5b: timer_done on the timeout cycle wins
        brew_start = 1'b1;
        for (int i = 0; i < c_TO; i++) cyc(14'd0, 2'd3, 1'b1, 1'b0, 1'b0);
        timer_done = 1'b1;
        cyc(14'd2000, 2'd0, 1'b0, 1'b1, 1'b0);

        // 6: asynchronous reset mid-brew
        brew_start = 1'b1;
        for (int i = 0; i < 3; i++) cyc(14'd0, 2'd3, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_now("async_reset", '{d:14'd0, s:2'd0, a:1'b0, dn:1'b0, f:1'b0});
        @(negedge clk);
        reset = 1'b0;
        cyc(14'd2000, 2'd0, 1'b0, 1'b0, 1'b0);

        // Every expectation must have been consumed by the monitor.
        @(posedge clk);
        #2;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
